axi_id_alloc: RTL and testbench
===============================

// Module: axi_id_alloc
// PURPOSE
//  Master-side AXI4 ID allocator. Issues unique ARID/AWID values and tracks which IDs are outstanding.
//  Retires an ID on its read-last or write-response handshake, so the slave side can echo IDs back.
//  Sits between the core's AR/AW request path and the interconnect, and gates ARVALID/AWVALID
//  while no free ID exists.
// PARAMETERS
//  ID_W     4   width of arid/awid/rid/bid
//  NUM_IDS  16  IDs managed per channel; must satisfy 1 <= NUM_IDS <= 2**ID_W
//  CNT_W    $clog2(NUM_IDS+1)  width of outstanding counters (localparam)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous reset, active-low
//  arvalid_in     in   1      core requests a read address beat
//  arvalid        out  1      to interconnect: arvalid_in & (id held | read ID free)
//  arready        in   1      from interconnect
//  arid           out  ID_W   ID attached to the current AR beat
//  rvalid,rready  in   1      read data handshake (observed)
//  rlast          in   1      last read beat
//  rid            in   ID_W   returned read ID
//  awvalid_in     in   1      core requests a write address beat
//  awvalid        out  1      gated as for arvalid
//  awready        in   1      from interconnect
//  awid           out  ID_W   ID attached to the current AW beat
//  bvalid,bready  in   1      write response handshake (observed)
//  bid            in   ID_W   returned write ID
//  ar_full        out  1      all read IDs outstanding
//  aw_full        out  1      all write IDs outstanding
//  ar_outstanding out  CNT_W  read IDs in flight
//  aw_outstanding out  CNT_W  write IDs in flight
// BEHAVIOUR
//  Per channel: NUM_IDS-bit busy bitmap; candidate ID = lowest-index clear bit (priority encoder).
//  Reset (rst==0 at posedge): bitmaps clear, counters 0, hold flags 0, arid/awid 0, ar_full/aw_full 0,
//  err outputs 0. Reset mid-transaction drops all tracking.
//  Hold: when arvalid goes high and arready is low, arid is latched and held until the handshake.
//  The held arid stays fixed even if a lower ID frees meanwhile (AXI stability rule); arvalid stays high.
//  Allocate on arvalid&arready: busy[arid] set at that edge; count +1. Zero added latency.
//  Next arid is valid the following cycle.
//  Free on rvalid&rready&rlast: busy[rid] cleared; count -1. Non-last beats do not free.
//  Write side: identical, using aw*/bvalid&bready&bid; there is no last qualifier on B.
//  Same-cycle alloc + free: both applied; count unchanged; a freed ID is never reissued in the
//  cycle it frees.
//  Full: ar_full = (count==NUM_IDS), registered with the count. While full and not holding,
//  arvalid = 0 and arid holds its last value.
//  Free of an ID that is not busy: bitmap and count unchanged (no underflow).
//  arid/awid width: index zero-extended to ID_W. IDs >= NUM_IDS are never issued.
//  Read and write channels are fully independent; the same numeric ID may be in flight on both.
// CONFIGURATION
//  ID_ERR_CHECK_EN defined: adds outputs r_id_err and b_id_err (out, 1).
//   Each is a one-cycle registered pulse when a freeing handshake carries an ID that is not busy
//   or is >= NUM_IDS.
//  ID_ERR_CHECK_EN undefined: those ports are absent. Stray frees are silently ignored.
// STRUCTURE
//  Package axi_id_pkg: ID_W/NUM_IDS defaults, CNT_W function, and the lowest-free-index priority-encoder
//  function.
//  Sub-module axi_id_pool: one bitmap, counter, hold latch and error check, instantiated twice
//  (read, write).
//  The top-level block only wires and gates valids.
// TESTING
//  T1 reset: rst=0 two cycles -> arid=0, awid=0, counts 0, full 0, arvalid=0 even with arvalid_in=1.
//  T2 issue three reads with arready=1 -> arid 0,1,2 on successive beats. ar_outstanding=3.
//  T3 return rid=1 rlast=1, then new read -> arid=1. A non-last beat with rid=0 frees nothing.
//  T4 fill all 16 read IDs -> ar_full=1 and arvalid=0. Then one B handshake on bid=0 leaves the read
//     side unaffected. Then rid=7 last -> next arid=7, ar_full=0.
//  T5 awvalid held with awready=0 for 5 cycles at awid=3 while bid=0 frees -> awid stays 3 until
//     handshake. Next awid=0.
//  T6 (ID_ERR_CHECK_EN) bvalid&bready bid=9 not busy -> b_id_err pulses 1 cycle; aw_outstanding
//     unchanged.

Source files
------------

// File: rtl/axi_id_pkg.sv
// Shared defaults and helpers for the AXI ID allocator: counter width and
// lowest-free-index priority encoder.
package axi_id_pkg;

    localparam int DEF_ID_W    = 4;
    localparam int DEF_NUM_IDS = 16;
    localparam int MAX_IDS     = 64;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Returns the lowest index below n whose busy bit is clear, or n when none is free.
    function automatic int lowest_free(input logic [MAX_IDS-1:0] busy, input int n);
        int r;
        r = n;
        for (int i = MAX_IDS - 1; i >= 0; i--) begin
            if (i < n && !busy[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_id_pool.sv
// One channel's ID pool: busy bitmap, outstanding counter, AXI hold latch and
// optional stray-free error pulse (ID_ERR_CHECK_EN).
module axi_id_pool
    import axi_id_pkg::*;
#(
    parameter int  ID_W    = DEF_ID_W,
    parameter int  NUM_IDS = DEF_NUM_IDS,
    localparam int CNT_W   = cnt_w(NUM_IDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             ready,
    input  logic             free_vld,
    input  logic [ID_W-1:0]  free_id,
    output logic             valid,
    output logic [ID_W-1:0]  id,
    output logic             full,
    output logic [CNT_W-1:0] outstanding
`ifdef ID_ERR_CHECK_EN
    ,
    output logic             err
`endif
);

    logic [NUM_IDS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_q, hold_d;
    logic               full_q, full_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;
    logic [MAX_IDS-1:0] busy_ext;
    logic [ID_W-1:0]    cand;
    logic               fire;
    logic               free_ok;

    always_comb begin
        busy_ext = '1;
        busy_ext[NUM_IDS-1:0] = busy_q;
        cand  = ID_W'(lowest_free(busy_ext, NUM_IDS));
        valid = rst & req & (hold_q | ~full_q);
        // A held or full channel keeps presenting the last ID it showed.
        id    = (hold_q | full_q) ? id_q : cand;
        fire  = valid & ready;

        free_ok = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (free_vld && free_id == ID_W'(i) && busy_q[i]) free_ok = 1'b1;
        end

        busy_d = busy_q;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (free_ok && free_id == ID_W'(i)) busy_d[i] = 1'b0;
            if (fire && id == ID_W'(i))         busy_d[i] = 1'b1;
        end

        cnt_d  = cnt_q + CNT_W'(fire) - CNT_W'(free_ok);
        full_d = (cnt_d == CNT_W'(NUM_IDS));
        hold_d = hold_q;
        if (valid) hold_d = ~ready;
        id_d   = id;
        err_d  = free_vld & ~free_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            hold_q <= 1'b0;
            full_q <= 1'b0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            full_q <= full_d;
            id_q   <= id_d;
            err_q  <= err_d;
        end
    end

    assign full        = full_q;
    assign outstanding = cnt_q;
`ifdef ID_ERR_CHECK_EN
    assign err         = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: rtl/axi_id_alloc.sv
// Master-side AXI4 ARID/AWID allocator: one ID pool per channel, retire on
// RLAST / B handshakes. ID_ERR_CHECK_EN adds r_id_err / b_id_err pulses.
module axi_id_alloc
    import axi_id_pkg::*;
#(
    parameter int  ID_W    = DEF_ID_W,
    parameter int  NUM_IDS = DEF_NUM_IDS,
    localparam int CNT_W   = cnt_w(NUM_IDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arvalid_in,
    output logic             arvalid,
    input  logic             arready,
    output logic [ID_W-1:0]  arid,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    input  logic [ID_W-1:0]  rid,
    input  logic             awvalid_in,
    output logic             awvalid,
    input  logic             awready,
    output logic [ID_W-1:0]  awid,
    input  logic             bvalid,
    input  logic             bready,
    input  logic [ID_W-1:0]  bid,
    output logic             ar_full,
    output logic             aw_full,
    output logic [CNT_W-1:0] ar_outstanding,
    output logic [CNT_W-1:0] aw_outstanding
`ifdef ID_ERR_CHECK_EN
    ,
    output logic             r_id_err,
    output logic             b_id_err
`endif
);

    logic r_free;
    logic b_free;

    assign r_free = rvalid & rready & rlast;
    assign b_free = bvalid & bready;

    axi_id_pool #(.ID_W(ID_W), .NUM_IDS(NUM_IDS)) u_rd_pool (
        .clk         (clk),
        .rst         (rst),
        .req         (arvalid_in),
        .ready       (arready),
        .free_vld    (r_free),
        .free_id     (rid),
        .valid       (arvalid),
        .id          (arid),
        .full        (ar_full),
        .outstanding (ar_outstanding)
`ifdef ID_ERR_CHECK_EN
        ,
        .err         (r_id_err)
`endif
    );

    axi_id_pool #(.ID_W(ID_W), .NUM_IDS(NUM_IDS)) u_wr_pool (
        .clk         (clk),
        .rst         (rst),
        .req         (awvalid_in),
        .ready       (awready),
        .free_vld    (b_free),
        .free_id     (bid),
        .valid       (awvalid),
        .id          (awid),
        .full        (aw_full),
        .outstanding (aw_outstanding)
`ifdef ID_ERR_CHECK_EN
        ,
        .err         (b_id_err)
`endif
    );

endmodule

// File: tb/tb_axi_id_alloc.sv
// Bench for axi_id_alloc: directed scenarios plus random traffic against a
// bitmap-level reference model of both channels.
module tb_axi_id_alloc;

    localparam int ID_W  = 4;
    localparam int NUM   = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             arvalid_in, arvalid, arready;
    logic [ID_W-1:0]  arid;
    logic             rvalid, rready, rlast;
    logic [ID_W-1:0]  rid;
    logic             awvalid_in, awvalid, awready;
    logic [ID_W-1:0]  awid;
    logic             bvalid, bready;
    logic [ID_W-1:0]  bid;
    logic             ar_full, aw_full;
    logic [CNT_W-1:0] ar_outstanding, aw_outstanding;
`ifdef ID_ERR_CHECK_EN
    logic             r_id_err, b_id_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_id_alloc #(.ID_W(ID_W), .NUM_IDS(NUM)) dut (
        .clk(clk), .rst(rst),
        .arvalid_in(arvalid_in), .arvalid(arvalid), .arready(arready), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
        .awvalid_in(awvalid_in), .awvalid(awvalid), .awready(awready), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .ar_full(ar_full), .aw_full(aw_full),
        .ar_outstanding(ar_outstanding), .aw_outstanding(aw_outstanding)
`ifdef ID_ERR_CHECK_EN
        , .r_id_err(r_id_err), .b_id_err(b_id_err)
`endif
    );

    // Reference model, channel 0 = read, 1 = write.
    bit mbusy [2][NUM];
    bit mhold [2];
    int mheld [2];
    int mlast [2];
    bit merr  [2];

    function automatic int mcnt(input int c);
        int n = 0;
        for (int i = 0; i < NUM; i++) n += int'(mbusy[c][i]);
        return n;
    endfunction

    function automatic bit mfull(input int c);
        return mcnt(c) == NUM;
    endfunction

    function automatic int mid(input int c);
        if (mhold[c] || mfull(c)) return mhold[c] ? mheld[c] : mlast[c];
        for (int i = 0; i < NUM; i++) if (!mbusy[c][i]) return i;
        return 0;
    endfunction

    function automatic bit mvalid(input int c, input bit req);
        return rst && req && (mhold[c] || !mfull(c));
    endfunction

    function automatic int pick_busy(input int c);
        int s = int'($urandom_range(0, NUM - 1));
        for (int k = 0; k < NUM; k++) if (mbusy[c][(s + k) % NUM]) return (s + k) % NUM;
        return s;
    endfunction

    task automatic model_edge(input int c, input bit req, input bit rdy, input bit fv, input int fid);
        bit v;
        int id;
        if (!rst) begin
            for (int i = 0; i < NUM; i++) mbusy[c][i] = 1'b0;
            mhold[c] = 0; mheld[c] = 0; mlast[c] = 0; merr[c] = 0;
            return;
        end
        v  = mvalid(c, req);
        id = mid(c);
        merr[c] = fv && !mbusy[c][fid];
        if (fv && mbusy[c][fid]) mbusy[c][fid] = 1'b0;
        if (v && rdy) mbusy[c][id] = 1'b1;
        if (v) begin
            mhold[c] = !rdy;
            mheld[c] = id;
        end
        mlast[c] = id;
    endtask

    task automatic tick();
        model_edge(0, arvalid_in, arready, rvalid & rready & rlast, int'(rid));
        model_edge(1, awvalid_in, awready, bvalid & bready, int'(bid));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; arvalid_in = 1'b1; awvalid_in = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({arid, awid} !== 8'h00) begin
            failures++; $display("FAIL reset_ids got arid=%0d awid=%0d want 0 0", arid, awid);
        end
        checks++;
        if ({ar_outstanding, aw_outstanding, ar_full, aw_full} !== 12'h0) begin
            failures++; $display("FAIL reset_counts got %0d %0d full %b %b want 0 0 0 0",
                                 ar_outstanding, aw_outstanding, ar_full, aw_full);
        end
        checks++;
        if ({arvalid, awvalid} !== 2'b00) begin
            failures++; $display("FAIL reset_valid got %b%b want 00", arvalid, awvalid);
        end
        arvalid_in = 1'b0; awvalid_in = 1'b0; rst = 1'b1;
    endtask

    task automatic test_issue();
        arvalid_in = 1'b1; arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (arid !== ID_W'(i) || arvalid !== 1'b1) begin
                failures++; $display("FAIL issue_arid got %0d v=%b want %0d v=1", arid, arvalid, i);
            end
            tick();
        end
        arvalid_in = 1'b0;
        #1;
        checks++;
        if (ar_outstanding !== 5'd3) begin
            failures++; $display("FAIL issue_count got %0d want 3", ar_outstanding);
        end
    endtask

    task automatic test_rlast_free();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = 4'd1;
        tick();
        rvalid = 1'b0; arvalid_in = 1'b1; arready = 1'b1;
        #1;
        checks++;
        if (arid !== 4'd1) begin
            failures++; $display("FAIL reuse_freed got arid=%0d want 1", arid);
        end
        tick();
        arvalid_in = 1'b0; rvalid = 1'b1; rlast = 1'b0; rid = 4'd0;
        tick();
        rvalid = 1'b0;
        #1;
        checks++;
        if (ar_outstanding !== 5'd3 || arid !== 4'd3) begin
            failures++; $display("FAIL nonlast_beat got cnt=%0d arid=%0d want 3 3", ar_outstanding, arid);
        end
    endtask

    task automatic test_full();
        arvalid_in = 1'b1; arready = 1'b1;
        for (int k = 0; k < 13; k++) tick();
        #1;
        checks++;
        if (ar_full !== 1'b1 || arvalid !== 1'b0 || ar_outstanding !== 5'd16) begin
            failures++; $display("FAIL full_gate got full=%b v=%b cnt=%0d want 1 0 16",
                                 ar_full, arvalid, ar_outstanding);
        end
        bvalid = 1'b1; bready = 1'b1; bid = 4'd0;
        tick();
        bvalid = 1'b0;
        #1;
        checks++;
        if (ar_full !== 1'b1 || ar_outstanding !== 5'd16 || aw_outstanding !== 5'd0) begin
            failures++; $display("FAIL b_isolation got full=%b rcnt=%0d wcnt=%0d want 1 16 0",
                                 ar_full, ar_outstanding, aw_outstanding);
        end
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = 4'd7;
        tick();
        rvalid = 1'b0;
        #1;
        checks++;
        if (arid !== 4'd7 || ar_full !== 1'b0 || arvalid !== 1'b1) begin
            failures++; $display("FAIL unfull got arid=%0d full=%b v=%b want 7 0 1", arid, ar_full, arvalid);
        end
        arvalid_in = 1'b0; arready = 1'b0;
    endtask

    task automatic test_hold();
        rst = 1'b0; tick(); rst = 1'b1;
        awvalid_in = 1'b1; awready = 1'b1;
        tick(); tick(); tick();
        awready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bvalid = (k == 0); bready = 1'b1; bid = 4'd0;
            #1;
            checks++;
            if (awid !== 4'd3 || awvalid !== 1'b1) begin
                failures++; $display("FAIL hold_awid cyc%0d got %0d v=%b want 3 v=1", k, awid, awvalid);
            end
            tick();
        end
        bvalid = 1'b0; awready = 1'b1;
        #1;
        checks++;
        if (awid !== 4'd3) begin
            failures++; $display("FAIL hold_release got awid=%0d want 3", awid);
        end
        tick();
        awready = 1'b0; awvalid_in = 1'b0;
        #1;
        checks++;
        if (awid !== 4'd0 || aw_outstanding !== 5'd3) begin
            failures++; $display("FAIL after_hold got awid=%0d cnt=%0d want 0 3", awid, aw_outstanding);
        end
    endtask

`ifdef ID_ERR_CHECK_EN
    task automatic test_id_err();
        bvalid = 1'b1; bready = 1'b1; bid = 4'd9;
        tick();
        bvalid = 1'b0;
        #1;
        checks++;
        if (b_id_err !== 1'b1 || aw_outstanding !== 5'd3 || r_id_err !== 1'b0) begin
            failures++; $display("FAIL stray_b got berr=%b rerr=%b cnt=%0d want 1 0 3",
                                 b_id_err, r_id_err, aw_outstanding);
        end
        tick();
        #1;
        checks++;
        if (b_id_err !== 1'b0) begin
            failures++; $display("FAIL stray_b_pulse got %b want 0", b_id_err);
        end
    endtask
`endif

    task automatic test_random();
        rst = 1'b0; tick(); rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            arvalid_in = mhold[0] ? 1'b1 : ($urandom_range(0, 3) != 0);
            awvalid_in = mhold[1] ? 1'b1 : ($urandom_range(0, 3) != 0);
            arready = $urandom_range(0, 1) == 1;
            awready = $urandom_range(0, 1) == 1;
            rvalid = $urandom_range(0, 2) == 0; rready = $urandom_range(0, 3) != 0;
            rlast  = $urandom_range(0, 1) == 1;
            bvalid = $urandom_range(0, 2) == 0; bready = $urandom_range(0, 3) != 0;
            rid = ID_W'(($urandom_range(0, 4) != 0) ? pick_busy(0) : int'($urandom_range(0, NUM - 1)));
            bid = ID_W'(($urandom_range(0, 4) != 0) ? pick_busy(1) : int'($urandom_range(0, NUM - 1)));
            #1;
            checks++;
            if ({arvalid, arid, ar_full, ar_outstanding} !==
                {mvalid(0, arvalid_in), ID_W'(mid(0)), mfull(0), CNT_W'(mcnt(0))}) begin
                failures++;
                $display("FAIL rand_rd cyc%0d got v=%b id=%0d full=%b cnt=%0d want v=%b id=%0d full=%b cnt=%0d",
                         n, arvalid, arid, ar_full, ar_outstanding,
                         mvalid(0, arvalid_in), mid(0), mfull(0), mcnt(0));
            end
            checks++;
            if ({awvalid, awid, aw_full, aw_outstanding} !==
                {mvalid(1, awvalid_in), ID_W'(mid(1)), mfull(1), CNT_W'(mcnt(1))}) begin
                failures++;
                $display("FAIL rand_wr cyc%0d got v=%b id=%0d full=%b cnt=%0d want v=%b id=%0d full=%b cnt=%0d",
                         n, awvalid, awid, aw_full, aw_outstanding,
                         mvalid(1, awvalid_in), mid(1), mfull(1), mcnt(1));
            end
`ifdef ID_ERR_CHECK_EN
            checks++;
            if ({r_id_err, b_id_err} !== {merr[0], merr[1]}) begin
                failures++; $display("FAIL rand_err cyc%0d got %b%b want %b%b",
                                     n, r_id_err, b_id_err, merr[0], merr[1]);
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        arvalid_in = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0; rid = '0;
        awvalid_in = 0; awready = 0; bvalid = 0; bready = 0; bid = '0;
        @(negedge clk);
        test_reset();
        test_issue();
        test_rlast_free();
        test_full();
        test_hold();
`ifdef ID_ERR_CHECK_EN
        test_id_err();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
